crop_pad_filter: RTL and testbench



---
 rtl/crop_pkg.sv | 17 +
 rtl/raster_counter.sv | 37 +++
 rtl/crop_pad_filter.sv | 88 ++++++++
 tb/tb_crop_pad_filter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/crop_pkg.sv
// Shared definitions for the crop / crop-pad raster stages.
package crop_pkg;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  // Counter width able to hold 0..n (one spare bit above $clog2).
  function automatic int unsigned cnt_width(input int unsigned n);
    return 32'($clog2(n)) + 32'd1;
  endfunction

  function automatic logic in_window(input int unsigned y, input int unsigned x,
                                     input int unsigned y1, input int unsigned x1,
                                     input int unsigned rows, input int unsigned cols);
    return (y >= y1) && (y < y1 + rows) && (x >= x1) && (x < x1 + cols);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter (column x, row y) that wraps at the end of a ROWS x COLS frame.
module raster_counter
  import crop_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  output logic [cnt_width(COLS)-1:0]    x,
  output logic [cnt_width(ROWS)-1:0]    y,
  output logic                          last
);

  localparam int unsigned XW = cnt_width(COLS);
  localparam int unsigned YW = cnt_width(ROWS);
  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/crop_pad_filter.sv
// Places a cropped raster stream into a larger frame at (Y_1, X_1), padding the rest.
module crop_pad_filter
  import crop_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH = 12,
  parameter int unsigned IN_ROWS         = 20,
  parameter int unsigned IN_COLS         = 20,
  parameter int unsigned OUT_ROWS        = 40,
  parameter int unsigned OUT_COLS        = 40,
  parameter int unsigned Y_1             = 10,
  parameter int unsigned X_1             = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int unsigned XW = cnt_width(OUT_COLS);
  localparam int unsigned YW = cnt_width(OUT_ROWS);

  generate
    if ((Y_1 + IN_ROWS > OUT_ROWS) || (X_1 + IN_COLS > OUT_COLS)) begin : g_bad_window
      $error("crop_pad_filter: input window does not fit inside the output frame");
    end
  endgenerate

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last;
  logic          in_win;
  logic          load_ok;
  logic          load_pix;
  logic          load_pad;
  logic          load;

  assign in_win   = in_window(32'(y), 32'(x), Y_1, X_1, IN_ROWS, IN_COLS);
  assign load_ok  = !out_valid || out_ready;
  assign in_ready = !reset && (state == ACTIVE) && in_win && load_ok;
  assign load_pix = in_valid && in_ready;
  // Pads need no input: emitted whenever the output register can take a beat.
  assign load_pad = !reset && (state == ACTIVE) && !in_win && load_ok;
  assign load     = load_pix || load_pad;

  raster_counter #(
    .ROWS (OUT_ROWS),
    .COLS (OUT_COLS)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .x     (x),
    .y     (y),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_SOF;
      pixel_out <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (load) begin
        pixel_out <= load_pix ? pixel_in : PAD_VALUE;
        out_valid <= 1'b1;
        out_last  <= last;
      end else if (load_ok) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      // A new frame starts only once upstream presents data again.
      case (state)
        WAIT_SOF: if (in_valid) state <= ACTIVE;
        ACTIVE:   if (load && last) state <= WAIT_SOF;
        default:  state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_crop_pad_filter.sv
// Table-driven scoreboard bench for crop_pad_filter (4x4 frame at (1,1) and 3x3 frame at (0,0)).
module tb_crop_pad_filter;

  localparam int unsigned PW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          iv   [2];
  logic [PW-1:0] pin  [2];
  logic          ordy [2];
  logic          ir   [2];
  logic [PW-1:0] pout [2];
  logic          ov   [2];
  logic          ol   [2];

  crop_pad_filter #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(2), .IN_COLS(2), .OUT_ROWS(4), .OUT_COLS(4),
    .Y_1(1), .X_1(1), .PAD_VALUE(12'd0)
  ) u_a (
    .clk(clk), .reset(reset), .pixel_in(pin[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .pixel_out(pout[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_last(ol[0])
  );

  crop_pad_filter #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(2), .IN_COLS(2), .OUT_ROWS(3), .OUT_COLS(3),
    .Y_1(0), .X_1(0), .PAD_VALUE(12'd0)
  ) u_b (
    .clk(clk), .reset(reset), .pixel_in(pin[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .pixel_out(pout[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_last(ol[1])
  );

  typedef struct {
    int sel;
    int n_in;
    int px[4];
    int n_out;
    int exp[16];
    int rdy_pct;
    int hold_after;
    int hold_cyc;
    int exp_bub;
    int reset_at;
  } vec_t;

  localparam int NVEC = 7;
  vec_t tbl[NVEC];
  int   sbq[$];
  int   total = 0;
  int   bad   = 0;

  int exp_a1[16] = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};
  int exp_a2[16] = '{0, 0, 0, 0, 0, 11, 22, 0, 0, 33, 44, 0, 0, 0, 0, 0};
  int exp_b[16]  = '{7, 8, 0, 9, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int sel, input int p0, input int p1, input int p2,
                              input int p3, input int n_out, input int rdy, input int hold_after,
                              input int hold_cyc, input int bub, input int rst_at);
    vec_t v;
    v.sel = sel; v.n_in = 4;
    v.px[0] = p0; v.px[1] = p1; v.px[2] = p2; v.px[3] = p3;
    v.n_out = n_out; v.rdy_pct = rdy; v.hold_after = hold_after; v.hold_cyc = hold_cyc;
    v.exp_bub = bub; v.reset_at = rst_at;
    for (int i = 0; i < 16; i++) v.exp[i] = 0;
    return v;
  endfunction

  task automatic idle_inputs();
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; pin[s] = '0; ordy[s] = 1'b1;
    end
  endtask

  // Drives one frame on DUT v.sel and checks every consumed beat against the scoreboard.
  task automatic run_frame(input int t);
    vec_t v;
    int s, in_idx, beats, cyc, bubbles, first_ov, hold_left, req;
    logic stall;
    logic [PW-1:0] prev_px;
    v = tbl[t];
    s = v.sel;
    in_idx = 0; beats = 0; cyc = 0; bubbles = 0; first_ov = -1; hold_left = 0;
    stall = 1'b0; prev_px = '0;
    for (int i = 0; i < v.n_out; i++) sbq.push_back(v.exp[i]);
    while (beats < v.n_out && cyc < 400) begin
      @(negedge clk);
      if (v.reset_at != 0 && beats == v.reset_at) begin
        reset = 1'b1;
        idle_inputs();
        #1;
        chk("in_ready_in_reset", int'(ir[s]), 0);
        @(negedge clk);
        #1;
        chk("valid_after_reset", int'(ov[s]), 0);
        chk("last_after_reset", int'(ol[s]), 0);
        reset = 1'b0;
        sbq.delete();
        return;
      end
      if (hold_left > 0) begin
        iv[s] = 1'b0;
        hold_left--;
      end else if (in_idx < v.n_in) begin
        iv[s] = 1'b1;
        pin[s] = PW'(v.px[in_idx]);
      end else begin
        iv[s] = 1'b0;
      end
      ordy[s] = (int'($urandom_range(99)) < v.rdy_pct);
      #1;
      if (ov[s] && first_ov < 0) begin
        first_ov = cyc;
        chk("first_latency", first_ov, 2);
      end
      if (stall) begin
        chk("stall_valid", int'(ov[s]), 1);
        chk("stall_pixel", int'(pout[s]), int'(prev_px));
      end
      if (ov[s] && !ordy[s]) chk("in_ready_bp", int'(ir[s]), 0);
      if (!ov[s] && first_ov >= 0) bubbles++;
      if (ov[s] && ordy[s]) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          req = sbq.pop_front();
          chk($sformatf("pixel[%0d]", beats), int'(pout[s]), req);
        end
        chk($sformatf("last[%0d]", beats), int'(ol[s]), (beats == v.n_out - 1) ? 1 : 0);
        beats++;
      end
      if (iv[s] && ir[s]) begin
        in_idx++;
        if (in_idx == v.hold_after) hold_left = v.hold_cyc;
      end
      stall = ov[s] && !ordy[s];
      prev_px = pout[s];
      cyc++;
    end
    chk("beats", beats, v.n_out);
    chk("inputs_taken", in_idx, v.n_in);
    chk("bubbles", bubbles, v.exp_bub);
    chk("sb_empty", sbq.size(), 0);
    sbq.delete();
  endtask

  // Idle gap: no output may appear before upstream starts the next frame.
  task automatic gap_check(input int s);
    int seen;
    seen = 0;
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (ov[s]) seen++;
    end
    chk("gap_no_output", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(0, 1, 2, 3, 4, 16, 100, 0, 0, 0, 0);  tbl[0].exp = exp_a1;
    tbl[1] = mk(0, 1, 2, 3, 4, 16, 50, 0, 0, 0, 0);   tbl[1].exp = exp_a1;
    tbl[2] = mk(0, 1, 2, 3, 4, 16, 100, 1, 5, 5, 0);  tbl[2].exp = exp_a1;
    tbl[3] = mk(1, 7, 8, 9, 10, 9, 100, 0, 0, 0, 0);  tbl[3].exp = exp_b;
    tbl[4] = mk(0, 1, 2, 3, 4, 16, 100, 0, 0, 0, 8);  tbl[4].exp = exp_a1;
    tbl[5] = mk(0, 1, 2, 3, 4, 16, 100, 0, 0, 0, 0);  tbl[5].exp = exp_a1;
    tbl[6] = mk(0, 11, 22, 33, 44, 16, 70, 0, 0, 0, 0); tbl[6].exp = exp_a2;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", int'(ov[s]), 0);
      chk("rst_last", int'(ol[s]), 0);
      chk("rst_pixel", int'(pout[s]), 0);
      chk("rst_in_ready", int'(ir[s]), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < NVEC; t++) begin
      run_frame(t);
      gap_check(tbl[t].sel);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
